// File: rtl/pe_pkt_pkg.sv
// Hoplite PE packet definitions shared by the PE injector and the PE sink:
// address-width derivation, field slicing, reserved-bit check and the sink
// FSM state encoding. Packet layout (LSB first): dest {x,y}, src {x,y}, seq,
// then reserved bits that must be zero.
package pe_pkt_pkg;

  localparam int PKT_MAX_W = 64;
  typedef logic [PKT_MAX_W-1:0] pkt_wide_t;

  localparam int PKT_DEST_LSB = 0;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  function automatic int pkt_a_w(input int x_aw, input int y_aw);
    return x_aw + y_aw;
  endfunction

  function automatic int pkt_src_lsb(input int a_w);
    return a_w;
  endfunction

  function automatic int pkt_seq_lsb(input int a_w);
    return 2 * a_w;
  endfunction

  function automatic int pkt_used_w(input int a_w, input int seq_w);
    return 2 * a_w + seq_w;
  endfunction

  // Packets are zero-extended to pkt_wide_t before slicing.
  function automatic pkt_wide_t pkt_field(input pkt_wide_t pkt, input int lsb, input int w);
    pkt_wide_t mask;
    mask = (pkt_wide_t'(1) << w) - pkt_wide_t'(1);
    return (pkt >> lsb) & mask;
  endfunction

  function automatic logic pkt_rsvd_clear(input pkt_wide_t pkt, input int used_w);
    return (pkt >> used_w) == '0;
  endfunction

endpackage

// File: rtl/pe_sink_seen.sv
// Seen bitmap for the PE sink: one bit per (src, seq) pair with a
// single-cycle test-and-set port. The whole map clears in the reset cycle,
// so packets arriving right after reset are checked against a clean map.
module pe_sink_seen #(
  parameter int A_W   = 4,
  parameter int SEQ_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [A_W-1:0]   src_i,
  input  logic [SEQ_W-1:0] seq_i,
  input  logic             set_i,
  output logic             hit_o
);

  localparam int DEPTH = 2 ** (A_W + SEQ_W);

  logic [DEPTH-1:0]       seen_q;
  logic [DEPTH-1:0]       seen_d;
  logic [A_W+SEQ_W-1:0]   idx;

  assign idx   = {src_i, seq_i};
  assign hit_o = seen_q[idx];

  // Next map: mark the addressed pair when the sink accepts it.
  always_comb begin
    seen_d = seen_q;
    if (set_i) seen_d[idx] = 1'b1;
  end

  // Map register with synchronous full clear.
  always_ff @(posedge clk) begin
    if (rst) seen_q <= '0;
    else     seen_q <= seen_d;
  end

endmodule

// File: rtl/pe_sink.sv
// Hoplite torus PE sink: absorbs every ejected beat, checks destination and
// reserved bits, optionally detects duplicate (src, seq) pairs, counts
// accepted packets and reports done plus sticky errors.
// Optional duplicate detection: define PE_SINK_DUP_CHECK_EN.
//
// state | meaning
// RUN   | receiving, fewer than EXP_CNT accepted, no error
// DONE  | EXP_CNT accepted with no error; any further beat is an error
// ERR   | an error flag is set; terminal until rst, beats still counted
module pe_sink
  import pe_pkt_pkg::*;
#(
  parameter int P_W     = 16,
  parameter int X_AW    = 2,
  parameter int Y_AW    = 2,
  parameter int X_POS   = 0,
  parameter int Y_POS   = 0,
  parameter int SEQ_W   = 4,
  parameter int EXP_CNT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [P_W-1:0]       in_pkt,
  input  logic                 in_vld,
  output logic                 rx_vld,
  output logic [X_AW+Y_AW-1:0] rx_src,
  output logic [SEQ_W-1:0]     rx_seq,
  output logic [CNT_W-1:0]     rx_cnt,
  output logic                 done,
  output logic                 err_misroute,
  output logic                 err_dup,
  output logic                 err_extra,
  output logic                 err_seq_range
);

  localparam int A_W    = pkt_a_w(X_AW, Y_AW);
  localparam int USED_W = pkt_used_w(A_W, SEQ_W);
  localparam logic [A_W-1:0] MYPOS = A_W'((X_POS << Y_AW) | Y_POS);

  pkt_wide_t        pkt_w;
  logic [A_W-1:0]   dest;
  logic [A_W-1:0]   src;
  logic [SEQ_W-1:0] seq;
  logic             is_mine;
  logic             well_formed;
  logic             seen_hit;

  assign pkt_w       = pkt_wide_t'(in_pkt);
  assign dest        = A_W'(pkt_field(pkt_w, PKT_DEST_LSB, A_W));
  assign src         = A_W'(pkt_field(pkt_w, pkt_src_lsb(A_W), A_W));
  assign seq         = SEQ_W'(pkt_field(pkt_w, pkt_seq_lsb(A_W), SEQ_W));
  assign is_mine     = (dest == MYPOS);
  assign well_formed = pkt_rsvd_clear(pkt_w, USED_W);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q;
  logic             rx_vld_q;
  logic [A_W-1:0]   rx_src_q;
  logic [SEQ_W-1:0] rx_seq_q;
  // {misroute, dup, extra, seq_range}
  logic [3:0]       err_q, err_d;

  logic emit;
  logic accept;
  logic misroute_hit, range_hit, dup_hit, extra_hit;

  assign emit         = in_vld && is_mine && well_formed;
  assign accept       = emit && !seen_hit;
  assign misroute_hit = in_vld && !is_mine;
  assign range_hit    = in_vld && is_mine && !well_formed;
  assign dup_hit      = emit && seen_hit;
  assign extra_hit    = in_vld && (state_q == ST_DONE);

`ifdef PE_SINK_DUP_CHECK_EN
  pe_sink_seen #(
    .A_W   (A_W),
    .SEQ_W (SEQ_W)
  ) u_seen (
    .clk   (clk),
    .rst   (rst),
    .src_i (src),
    .seq_i (seq),
    .set_i (accept),
    .hit_o (seen_hit)
  );
`else
  assign seen_hit = 1'b0;
`endif

  // Counter, sticky errors and FSM next state for the current beat.
  always_comb begin
    cnt_d   = cnt_q;
    err_d   = err_q | {misroute_hit, dup_hit, extra_hit, range_hit};
    state_d = state_q;
    if (accept && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    case (state_q)
      ST_RUN: begin
        if (|err_d) state_d = ST_ERR;
        else if (accept && (cnt_d == CNT_W'(EXP_CNT))) state_d = ST_DONE;
      end
      ST_DONE: if (|err_d) state_d = ST_ERR;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_RUN;
    endcase
  end

  // State and output registers; reset discards the beat in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      err_q    <= '0;
      done_q   <= 1'b0;
      rx_vld_q <= 1'b0;
      rx_src_q <= '0;
      rx_seq_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      done_q   <= (state_d == ST_DONE);
      rx_vld_q <= emit;
      if (emit) begin
        rx_src_q <= src;
        rx_seq_q <= seq;
      end
    end
  end

  assign rx_vld        = rx_vld_q;
  assign rx_src        = rx_src_q;
  assign rx_seq        = rx_seq_q;
  assign rx_cnt        = cnt_q;
  assign done          = done_q;
  assign err_misroute  = err_q[3];
  assign err_dup       = err_q[2];
  assign err_extra     = err_q[1];
  assign err_seq_range = err_q[0];

endmodule

// File: tb/tb_pe_sink.sv
// Bench for pe_sink at PE(1,2) with default widths and EXP_CNT=16.
// Driver pushes expected decoded packets into a queue; a negedge monitor
// pops and compares them whenever rx_vld is seen.
module tb_pe_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_pkt;
  logic        in_vld;
  logic        rx_vld;
  logic [3:0]  rx_src;
  logic [3:0]  rx_seq;
  logic [15:0] rx_cnt;
  logic        done;
  logic        err_misroute, err_dup, err_extra, err_seq_range;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0] src;
    logic [3:0] seq;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  localparam logic [3:0] MY = 4'b0110;

  pe_sink #(
    .P_W(16), .X_AW(2), .Y_AW(2), .X_POS(1), .Y_POS(2),
    .SEQ_W(4), .EXP_CNT(16), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .in_pkt(in_pkt), .in_vld(in_vld),
    .rx_vld(rx_vld), .rx_src(rx_src), .rx_seq(rx_seq), .rx_cnt(rx_cnt),
    .done(done), .err_misroute(err_misroute), .err_dup(err_dup),
    .err_extra(err_extra), .err_seq_range(err_seq_range)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] rsv, input logic [3:0] seq,
                                     input logic [3:0] src, input logic [3:0] dst);
    return {rsv, seq, src, dst};
  endfunction

  // One clock of stimulus; exp_out queues the decoded packet expected next cycle.
  task automatic step(input logic r, input logic v, input logic [15:0] p, input logic exp_out);
    exp_t e;
    if (exp_out) begin
      e.src = p[7:4];
      e.seq = p[11:8];
      e.cyc = cyc + 1;
      sb.push_back(e);
    end
    rst    = r;
    in_vld = v;
    in_pkt = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic chk_flags(input string nm, input logic [3:0] exp);
    chk(nm, {28'd0, err_misroute, err_dup, err_extra, err_seq_range}, {28'd0, exp});
  endtask

  // Monitor: every rx_vld must match the head of the scoreboard, on time.
  always @(negedge clk) begin
    if (rx_vld === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rx_vld_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rx_src", {28'd0, rx_src}, {28'd0, e.src});
        chk("rx_seq", {28'd0, rx_seq}, {28'd0, e.seq});
        chk("rx_latency", cyc, e.cyc);
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      chk("rx_vld_missing", {31'd0, rx_vld}, 32'd1);
      void'(sb.pop_front());
    end
  end

  int perm[16] = '{5, 14, 0, 11, 3, 8, 13, 6, 1, 15, 10, 4, 9, 2, 7, 12};

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_pkt = '0;
    idle(0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("reset_cnt", {16'd0, rx_cnt}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_vld", {31'd0, rx_vld}, 32'd0);
    chk_flags("reset_flags", 4'b0000);

    // 16 distinct packets back-to-back in scrambled order.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, mk(4'd0, 4'(perm[i] % 4), 4'(perm[i] / 4), MY), 1'b1);
      if (i == 14) begin
        chk("cnt_at_15", {16'd0, rx_cnt}, 32'd15);
        chk("done_before_last", {31'd0, done}, 32'd0);
      end
    end
    chk("cnt_at_16", {16'd0, rx_cnt}, 32'd16);
    chk("done_after_16", {31'd0, done}, 32'd1);
    chk_flags("main_flags", 4'b0000);
    idle(2);
    chk("done_holds", {31'd0, done}, 32'd1);

    // Extra packet in DONE: flagged, still counted, done drops.
    step(1'b0, 1'b1, mk(4'd0, 4'd4, 4'd0, MY), 1'b1);
    chk("extra_flags", {28'd0, err_misroute, err_dup, err_extra, err_seq_range}, 32'b0010);
    chk("extra_done", {31'd0, done}, 32'd0);
    chk("extra_cnt", {16'd0, rx_cnt}, 32'd17);
    idle(2);

    // Misroute: no count, no rx_vld, FSM lands in ERR so done never rises.
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, mk(4'd0, 4'd1, 4'd1, 4'b0000), 1'b0);
    chk_flags("misroute_flags", 4'b1000);
    chk("misroute_cnt", {16'd0, rx_cnt}, 32'd0);
    chk("misroute_vld", {31'd0, rx_vld}, 32'd0);
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b1, mk(4'd0, 4'(i % 4), 4'(i / 4), MY), 1'b1);
    chk("err_cnt", {16'd0, rx_cnt}, 32'd16);
    chk("err_no_done", {31'd0, done}, 32'd0);
    idle(2);
    chk("err_still_no_done", {31'd0, done}, 32'd0);

    // Duplicate (src=3, seq=5).
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, mk(4'd0, 4'd5, 4'd3, MY), 1'b1);
    chk_flags("dup_first_flags", 4'b0000);
    chk("dup_first_cnt", {16'd0, rx_cnt}, 32'd1);
    step(1'b0, 1'b1, mk(4'd0, 4'd5, 4'd3, MY), 1'b1);
`ifdef PE_SINK_DUP_CHECK_EN
    chk_flags("dup_second_flags", 4'b0100);
    chk("dup_second_cnt", {16'd0, rx_cnt}, 32'd1);
`else
    chk_flags("dup_second_flags", 4'b0000);
    chk("dup_second_cnt", {16'd0, rx_cnt}, 32'd2);
`endif
    idle(1);

    // Reset mid-stream with a beat in flight: beat dropped, map cleared.
    step(1'b1, 1'b1, mk(4'd0, 4'd5, 4'd3, MY), 1'b0);
    chk("rst_mid_cnt", {16'd0, rx_cnt}, 32'd0);
    chk("rst_mid_vld", {31'd0, rx_vld}, 32'd0);
    chk("rst_mid_src", {28'd0, rx_src}, 32'd0);
    chk("rst_mid_seq", {28'd0, rx_seq}, 32'd0);
    chk_flags("rst_mid_flags", 4'b0000);
    step(1'b0, 1'b1, mk(4'd0, 4'd5, 4'd3, MY), 1'b1);
    chk("resend_cnt", {16'd0, rx_cnt}, 32'd1);
    chk_flags("resend_flags", 4'b0000);

    // Reserved bit 15 set: flagged, not counted, no rx_vld.
    step(1'b0, 1'b1, mk(4'b1000, 4'd6, 4'd2, MY), 1'b0);
    chk_flags("rsvd_flags", 4'b0001);
    chk("rsvd_cnt", {16'd0, rx_cnt}, 32'd1);
    chk("rsvd_vld", {31'd0, rx_vld}, 32'd0);
    chk("rsvd_done", {31'd0, done}, 32'd0);

    idle(3);
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
